regfile_sb: RTL and testbench



---
 rtl/regfile_sb_if.sv | 46 ++++
 rtl/regfile_sb.sv | 150 +++++++++++++++
 tb/tb_regfile_sb.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Bus bundle between the issue/write-back stages and the
//               scoreboarded register file.
//               master : issue/write-back side (drives read indices,
//                        reservations and write-back)
//               slave  : register file (returns read data, busy flags,
//                        issue readiness and init status)
//               rd_addr_i  [NUM_RD*ADDR_W] read indices, port k at k*ADDR_W
//               rd_data_o  [NUM_RD*DATA_W] read data,    port k at k*DATA_W
//               rd_busy_o  [NUM_RD]        read target has a pending write
//               issue_*                    destination reservation request
//               wb_*                       write-back strobe/index/data
//               init_done_o                init sweep finished
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
   logic [NUM_RD*DATA_W-1:0] rd_data_o;
   logic [NUM_RD-1:0]        rd_busy_o;
   logic                     issue_valid_i;
   logic [ADDR_W-1:0]        issue_addr_i;
   logic                     issue_ready_o;
   logic                     wb_valid_i;
   logic [ADDR_W-1:0]        wb_addr_i;
   logic [DATA_W-1:0]        wb_data_i;
   logic                     init_done_o;

   modport master (
      output rd_addr_i, issue_valid_i, issue_addr_i,
             wb_valid_i, wb_addr_i, wb_data_i,
      input  rd_data_o, rd_busy_o, issue_ready_o, init_done_o
   );

   modport slave (
      input  rd_addr_i, issue_valid_i, issue_addr_i,
             wb_valid_i, wb_addr_i, wb_data_i,
      output rd_data_o, rd_busy_o, issue_ready_o, init_done_o
   );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file with per-register scoreboard.
//               NUM_RD combinational read ports with write-back bypass, one
//               write-back port, and busy bits that let the issue stage
//               detect RAW/WAW hazards. After reset a sequential sweep
//               zeroes one entry per cycle so the array maps onto RAM.
//               clk_i : clock, all state updates on the rising edge
//               rst_i : synchronous active-high reset
//               bus   : regfile_sb_if slave modport (reads, issue, wb, init)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  wire logic     clk_i,
   input  wire logic     rst_i,
   regfile_sb_if.slave   bus
);

   localparam int              c_depth    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_last   = ADDR_W'(c_depth - 1);
   localparam bit              c_zero_reg = (ZERO_REG != 0);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_init_cnt;
   logic [ADDR_W-1:0]   w_init_cnt_nxt;
   logic [c_depth-1:0]  r_busy;
   logic [c_depth-1:0]  w_busy_nxt;

   logic [DATA_W-1:0]   r_mem [c_depth];

   // Single array write port shared by the init sweep and write-back.
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_data;

   logic                w_issue_ready;
   logic                w_wb_hits_issue;
   logic                w_wb_discard;

   assign w_wb_hits_issue = bus.wb_valid_i && (bus.wb_addr_i == bus.issue_addr_i);
   assign w_wb_discard    = c_zero_reg && (bus.wb_addr_i == '0);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         r_busy     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   // Storage has no reset so it can be inferred as RAM; the sweep clears it.
   always_ff @(posedge clk_i) begin
      if (w_mem_we && !rst_i) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state, scoreboard and write-port control
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      w_busy_nxt     = r_busy;
      w_mem_we       = 1'b0;
      w_mem_addr     = r_init_cnt;
      w_mem_data     = '0;
      w_issue_ready  = 1'b0;

      case (r_state)
         ST_INIT: begin
            w_mem_we       = 1'b1;
            w_init_cnt_nxt = r_init_cnt + ADDR_W'(1);
            if (r_init_cnt == c_last) begin
               w_state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            // A same-cycle write-back frees the destination for re-issue.
            w_issue_ready = !r_busy[bus.issue_addr_i] || w_wb_hits_issue;

            if (bus.wb_valid_i && !w_wb_discard) begin
               w_mem_we                   = 1'b1;
               w_mem_addr                 = bus.wb_addr_i;
               w_mem_data                 = bus.wb_data_i;
               w_busy_nxt[bus.wb_addr_i]  = 1'b0;
            end

            // Applied after the clear so a new reservation wins over it.
            if (bus.issue_valid_i && w_issue_ready &&
                !(c_zero_reg && (bus.issue_addr_i == '0))) begin
               w_busy_nxt[bus.issue_addr_i] = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Read ports: zero register, then bypass, then array
   // ------------------------------------------------------------------------
   always_comb begin
      logic [ADDR_W-1:0] v_addr;
      bus.rd_data_o = '0;
      bus.rd_busy_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         v_addr = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
         if (r_state == ST_RUN) begin
            if (c_zero_reg && (v_addr == '0)) begin
               bus.rd_data_o[k*DATA_W +: DATA_W] = '0;
               bus.rd_busy_o[k]                  = 1'b0;
            end else if (bus.wb_valid_i && (bus.wb_addr_i == v_addr)) begin
               bus.rd_data_o[k*DATA_W +: DATA_W] = bus.wb_data_i;
               bus.rd_busy_o[k]                  = 1'b0;
            end else begin
               bus.rd_data_o[k*DATA_W +: DATA_W] = r_mem[v_addr];
               bus.rd_busy_o[k]                  = r_busy[v_addr];
            end
         end
      end
   end

   assign bus.issue_ready_o = w_issue_ready;
   assign bus.init_done_o   = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb. Two instances share one
//               stimulus stream: u0 with ZERO_REG=1 and u1 with ZERO_REG=0.
//               A behavioural model (plain arrays and a cycle count since
//               reset) predicts every output once per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [NR*AW-1:0] ra;
   logic             iv;
   logic [AW-1:0]    ia;
   logic             wv;
   logic [AW-1:0]    wa;
   logic [DW-1:0]    wd;

   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if0 ();
   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if1 ();

   assign if0.rd_addr_i     = ra;
   assign if0.issue_valid_i = iv;
   assign if0.issue_addr_i  = ia;
   assign if0.wb_valid_i    = wv;
   assign if0.wb_addr_i     = wa;
   assign if0.wb_data_i     = wd;
   assign if1.rd_addr_i     = ra;
   assign if1.issue_valid_i = iv;
   assign if1.issue_addr_i  = ia;
   assign if1.wb_valid_i    = wv;
   assign if1.wb_addr_i     = wa;
   assign if1.wb_data_i     = wd;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u0 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if0.slave)
   );

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if1.slave)
   );

   logic [NR*DW-1:0] obs_data  [2];
   logic [NR-1:0]    obs_busy  [2];
   logic             obs_ready [2];
   logic             obs_done  [2];

   assign obs_data[0]  = if0.rd_data_o;
   assign obs_data[1]  = if1.rd_data_o;
   assign obs_busy[0]  = if0.rd_busy_o;
   assign obs_busy[1]  = if1.rd_busy_o;
   assign obs_ready[0] = if0.issue_ready_o;
   assign obs_ready[1] = if1.issue_ready_o;
   assign obs_done[0]  = if0.init_done_o;
   assign obs_done[1]  = if1.init_done_o;

   // Reference model: architectural contents, pending-write flags and the
   // number of clean cycles since reset.
   logic [DW-1:0] m_mem  [2][DEPTH];
   bit            m_busy [2][DEPTH];
   int            m_cyc;
   bit            m_run;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit zr(input int d);
      return (d == 0);
   endfunction

   // Compare every output with the model for the inputs currently applied.
   task automatic model_check();
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      bit            eb;
      bit            er;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < NR; k++) begin
            a = ra[k*AW +: AW];
            if (!m_run)                 begin ed = '0;            eb = 1'b0; end
            else if (zr(d) && a == 0)   begin ed = '0;            eb = 1'b0; end
            else if (wv && wa == a)     begin ed = wd;            eb = 1'b0; end
            else                        begin ed = m_mem[d][a];   eb = m_busy[d][a]; end
            check($sformatf("u%0d port%0d data r%0d", d, k, a), 64'(obs_data[d][k*DW +: DW]), 64'(ed));
            check($sformatf("u%0d port%0d busy r%0d", d, k, a), 64'(obs_busy[d][k]), 64'(eb));
         end
         er = m_run && (!m_busy[d][ia] || (wv && wa == ia));
         check($sformatf("u%0d issue_ready r%0d", d, ia), 64'(obs_ready[d]), 64'(er));
         check($sformatf("u%0d init_done", d), 64'(obs_done[d]), 64'(m_run));
      end
   endtask

   // Advance the model by one rising edge using the inputs held across it.
   task automatic model_update();
      bit acc;
      if (rst) begin
         m_cyc = 0;
         m_run = 1'b0;
         for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) m_busy[d][i] = 1'b0;
      end else if (!m_run) begin
         m_cyc++;
         if (m_cyc == DEPTH) begin
            m_run = 1'b1;
            for (int d = 0; d < 2; d++)
               for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            acc = iv && (!m_busy[d][ia] || (wv && wa == ia));
            if (wv && !(zr(d) && wa == 0)) begin
               m_mem[d][wa]  = wd;
               m_busy[d][wa] = 1'b0;
            end
            if (acc && !(zr(d) && ia == 0)) m_busy[d][ia] = 1'b1;
         end
      end
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      finish_cycle();
   endtask

   function automatic logic [AW-1:0] pick();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, DEPTH-1));
   endfunction

   task automatic rand_inputs();
      ra = NR*AW'($urandom);
      iv = 1'($urandom_range(0, 1));
      ia = pick();
      wv = 1'($urandom_range(0, 1));
      wa = pick();
      wd = $urandom;
   endtask

   task automatic quiet();
      iv = 1'b0;
      wv = 1'b0;
   endtask

   // Full sweep with random (ignored) traffic; init_done must rise after
   // exactly DEPTH clean edges.
   task automatic init_phase();
      for (int i = 0; i < DEPTH; i++) begin
         rand_inputs();
         @(negedge clk);
         model_check();
         check($sformatf("init_done low cycle %0d", i), 64'(obs_done[0]), 64'(0));
         check($sformatf("ready low cycle %0d", i), 64'(obs_ready[0]), 64'(0));
         finish_cycle();
      end
      quiet();
      @(negedge clk);
      model_check();
      check("init_done after DEPTH", 64'(obs_done[0]), 64'(1));
      finish_cycle();
   endtask

   task automatic read_sweep();
      quiet();
      for (int i = 0; i < DEPTH; i++) begin
         ra = {AW'(DEPTH-1-i), AW'(i)};
         step();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      quiet();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ra  = '0;
      ia  = '0;
      wa  = '0;
      wd  = '0;
      quiet();
      m_cyc = 0;
      m_run = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[d][i]  = '0;
            m_busy[d][i] = 1'b0;
         end

      @(posedge clk);
      model_update();
      #1;
      step();
      step();
      rst = 1'b0;
      init_phase();
      read_sweep();

      // Write-back bypass, then array read of r5
      ra = {AW'(0), AW'(5)};
      wv = 1'b1; wa = 5; wd = 32'hDEADBEEF;
      @(negedge clk); model_check();
      check("bypass r5", 64'(obs_data[0][DW-1:0]), 64'h0000_0000_DEAD_BEEF);
      finish_cycle();
      quiet();
      @(negedge clk); model_check();
      check("array r5", 64'(obs_data[0][DW-1:0]), 64'h0000_0000_DEAD_BEEF);
      finish_cycle();

      // Reserve r7, stall a second reservation, release with write-back
      ra = {AW'(0), AW'(7)};
      iv = 1'b1; ia = 7;
      @(negedge clk); model_check();
      check("r7 first issue ready", 64'(obs_ready[0]), 64'(1));
      finish_cycle();
      @(negedge clk); model_check();
      check("r7 busy", 64'(obs_busy[0][0]), 64'(1));
      check("r7 stall ready", 64'(obs_ready[0]), 64'(0));
      finish_cycle();
      iv = 1'b0; wv = 1'b1; wa = 7; wd = 32'h1234;
      @(negedge clk); model_check();
      check("r7 wb busy clear", 64'(obs_busy[0][0]), 64'(0));
      check("r7 wb ready", 64'(obs_ready[0]), 64'(1));
      finish_cycle();

      // Same-cycle issue and write-back to busy r9
      quiet();
      ra = {AW'(0), AW'(9)};
      iv = 1'b1; ia = 9;
      step();
      wv = 1'b1; wa = 9; wd = 32'h55;
      @(negedge clk); model_check();
      check("r9 issue+wb ready", 64'(obs_ready[0]), 64'(1));
      finish_cycle();
      quiet();
      @(negedge clk); model_check();
      check("r9 data", 64'(obs_data[0][DW-1:0]), 64'h55);
      check("r9 busy kept", 64'(obs_busy[0][0]), 64'(1));
      finish_cycle();
      wv = 1'b1; wa = 9; wd = $urandom;
      step();

      // Register 0 with and without ZERO_REG
      ra = {AW'(0), AW'(0)};
      wv = 1'b1; wa = 0; wd = 32'hFFFFFFFF;
      step();
      quiet();
      @(negedge clk); model_check();
      check("r0 zero_reg data", 64'(obs_data[0][DW-1:0]), 64'(0));
      check("r0 plain data", 64'(obs_data[1][DW-1:0]), 64'h0000_0000_FFFF_FFFF);
      finish_cycle();
      iv = 1'b1; ia = 0;
      @(negedge clk); model_check();
      check("r0 zero_reg issue ready", 64'(obs_ready[0]), 64'(1));
      finish_cycle();
      iv = 1'b0;
      @(negedge clk); model_check();
      check("r0 zero_reg busy", 64'(obs_busy[0][0]), 64'(0));
      check("r0 plain busy", 64'(obs_busy[1][0]), 64'(1));
      finish_cycle();
      wv = 1'b1; wa = 0; wd = $urandom;
      step();

      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         step();
      end

      // Reset in RUN with r3 reserved
      quiet();
      ra = {AW'(0), AW'(3)};
      iv = 1'b1; ia = 3; wv = 1'b1; wa = 3; wd = $urandom;
      step();
      quiet();
      @(negedge clk); model_check();
      check("r3 busy before reset", 64'(obs_busy[0][0]), 64'(1));
      finish_cycle();
      do_reset();
      init_phase();
      ra = {AW'(0), AW'(3)};
      @(negedge clk); model_check();
      check("r3 busy after reset", 64'(obs_busy[0][0]), 64'(0));
      finish_cycle();
      read_sweep();

      // Reset in the middle of the init sweep
      do_reset();
      for (int n = 0; n < 10; n++) begin
         rand_inputs();
         step();
      end
      do_reset();
      init_phase();
      read_sweep();

      for (int n = 0; n < 100; n++) begin
         rand_inputs();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
